decoder_scan: RTL and testbench

DECODER_SCAN -- requirements
Module: decoder_scan

---
 rtl/decoder_scan.sv | 92 +++++++++
 tb/tb_decoder_scan.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// One-hot decoder with a DIRECT mode (decode `in`) and a SCAN mode (decode a dwell-paced counter).
// Define DECODER_SCAN_ACTIVE_LOW_EN to make every bcode line active-low.
module decoder_scan #(
    parameter int N   = 3,
    parameter int DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic [N-1:0]     in,
    output logic [2**N-1:0]  bcode,
    output logic [N-1:0]     code,
    output logic             wrap
);

    localparam int W  = 2**N;
    localparam int DW = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DIV - 1);
    localparam logic [N-1:0]  CODE_MAX  = '1;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic [W-1:0] BCODE_IDLE = '1;
`else
    localparam logic [W-1:0] BCODE_IDLE = '0;
`endif

    typedef enum logic {ST_DIRECT, ST_SCAN} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    code_q,  code_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            wrap_q,  wrap_d;
    logic [W-1:0]    bcode_q, bcode_d;

    // XOR with the idle pattern flips the selected line to the active polarity.
    function automatic logic [W-1:0] decode(input logic [N-1:0] c);
        logic [W-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v ^ BCODE_IDLE;
    endfunction

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        bcode_d = BCODE_IDLE;
        if (en) begin
            if (mode) begin
                state_d = ST_SCAN;
                if (state_q == ST_DIRECT) begin
                    code_d  = '0;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_MAX) begin
                    dwell_d = '0;
                    code_d  = code_q + N'(1);
                    wrap_d  = (code_q == CODE_MAX);
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end else begin
                state_d = ST_DIRECT;
                code_d  = in;
                dwell_d = '0;
            end
            bcode_d = decode(code_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_DIRECT;
            code_q  <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            bcode_q <= BCODE_IDLE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            bcode_q <= bcode_d;
        end
    end

    assign bcode = bcode_q;
    assign code  = code_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: DIV=4 and DIV=1 instances against a counting reference model.
// Honors DECODER_SCAN_ACTIVE_LOW_EN for the expected bcode polarity.
module tb_decoder_scan;

    localparam int N = 3;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic [7:0] IDLE = 8'hFF;
`else
    localparam logic [7:0] IDLE = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] in_v = 3'd0;
    logic [7:0] bcode4, bcode1;
    logic [2:0] code4, code1;
    logic       wrap4, wrap1;

    always #5 clk = ~clk;

    decoder_scan #(.N(N), .DIV(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .in(in_v),
        .bcode(bcode4), .code(code4), .wrap(wrap4)
    );

    decoder_scan #(.N(N), .DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .in(in_v),
        .bcode(bcode1), .code(code1), .wrap(wrap1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: in SCAN, code is derived from the number of enabled cycles since entry.
    int divs[2]    = '{4, 1};
    int m_scan[2]  = '{0, 0};
    int m_el[2]    = '{0, 0};
    int m_dcode[2] = '{0, 0};
    int m_act[2]   = '{0, 0};
    int m_wrap[2]  = '{0, 0};

    function automatic int m_code(input int i);
        return (m_scan[i] != 0) ? (m_el[i] / divs[i]) % 8 : m_dcode[i];
    endfunction

    function automatic logic [7:0] exp_b(input int act, input int c);
        logic [7:0] one;
        one = 8'h01;
        return (act != 0) ? (IDLE ^ (one << c)) : IDLE;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_scan[i] = 0; m_el[i] = 0; m_dcode[i] = 0; m_act[i] = 0; m_wrap[i] = 0;
            end else if (!en) begin
                m_act[i] = 0; m_wrap[i] = 0;
            end else begin
                m_act[i] = 1;
                if (mode) begin
                    if (m_scan[i] == 0) begin
                        m_scan[i] = 1; m_el[i] = 0; m_wrap[i] = 0;
                    end else begin
                        m_el[i] = m_el[i] + 1;
                        m_wrap[i] = ((m_el[i] % (divs[i] * 8)) == 0) ? 1 : 0;
                    end
                end else begin
                    m_scan[i] = 0; m_dcode[i] = int'(in_v); m_wrap[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_bcode4", 32'(bcode4), 32'(exp_b(m_act[0], m_code(0))));
            chk("m_code4",  32'(code4),  32'(m_code(0)));
            chk("m_wrap4",  32'(wrap4),  32'(m_wrap[0]));
            chk("m_bcode1", 32'(bcode1), 32'(exp_b(m_act[1], m_code(1))));
            chk("m_code1",  32'(code1),  32'(m_code(1)));
            chk("m_wrap1",  32'(wrap1),  32'(m_wrap[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w4, w1, wk;
        logic [7:0] one;
        one = 8'h01;
        tick(); tick();
        chk("rst_bcode", 32'(bcode4), 32'(IDLE));
        chk("rst_code",  32'(code4), 32'd0);
        chk("rst_wrap",  32'(wrap4), 32'd0);
        chk_on = 1'b1;

        // Direct decode of every code
        reset = 1'b0; en = 1'b1; mode = 1'b0;
        for (int v = 0; v < 8; v++) begin
            in_v = 3'(v);
            tick();
            chk("direct_bcode", 32'(bcode4), 32'(IDLE ^ (one << v)));
            chk("direct_code",  32'(code4), 32'(v));
        end

        // Full scan cycle for both dwell settings
        mode = 1'b1; w4 = 0; w1 = 0; wk = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("scan_code4", 32'(code4), 32'(((k - 1) / 4) % 8));
            chk("scan_code1", 32'(code1), 32'((k - 1) % 8));
            if (wrap4) begin
                w4++;
                if (wk == 0) wk = k;
            end
            if (wrap1) w1++;
        end
        chk("wrap4_count", 32'(w4), 32'd1);
        chk("wrap4_cycle", 32'(wk), 32'd33);
        chk("wrap1_count", 32'(w1), 32'd4);

        // Enable pause in mid-dwell
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (23) tick();
        chk("pause_pre_code", 32'(code4), 32'd5);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pause_code",  32'(code4), 32'd5);
            chk("pause_bcode", 32'(bcode4), 32'(IDLE));
        end
        en = 1'b1;
        tick();
        chk("resume_code_a", 32'(code4), 32'd5);
        tick();
        chk("resume_code_b", 32'(code4), 32'd6);

        // Reset in the middle of a scan
        reset = 1'b1;
        tick();
        chk("midrst_code",  32'(code4), 32'd0);
        chk("midrst_bcode", 32'(bcode4), 32'(IDLE));
        chk("midrst_wrap",  32'(wrap4), 32'd0);
        reset = 1'b0; mode = 1'b0; in_v = 3'd2;
        tick();
        chk("post_rst_bcode", 32'(bcode4), 32'(IDLE ^ 8'h04));

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            reset = ($urandom_range(0, 60) == 0);
            en    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            in_v  = 3'($urandom_range(0, 7));
            tick();
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
